// File: rtl/rx_timing_ctrl.sv
// rx_timing_ctrl: sample/symbol strobe generation and measurement-window sequencing for the QPSK receiver.
// Define RX_TIMING_PHASE_ADJ_EN to enable one-sample symbol phase slips via phase_adv/phase_ret.
module rx_timing_ctrl #(
  parameter int unsigned CLK_PER_SAM = 4,
  parameter int unsigned SAM_PER_SYM = 4,
  parameter int unsigned SETTLE_SYMS = 32,
  parameter int unsigned LEN_W       = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           meas_start,
  input  logic [LEN_W-1:0]               meas_len,
  input  logic                           phase_adv,
  input  logic                           phase_ret,
  output logic                           sam_clk_ena,
  output logic                           sym_clk_ena,
  output logic                           acc_clear,
  output logic                           acc_en,
  output logic                           meas_busy,
  output logic                           meas_done,
  output logic [$clog2(SAM_PER_SYM)-1:0] phase_ofs
);

  localparam int unsigned CLK_W = $clog2(CLK_PER_SAM);
  localparam int unsigned SAM_W = $clog2(SAM_PER_SYM);
  localparam int unsigned OFS_W = $clog2(SAM_PER_SYM);
  localparam int unsigned SET_W = $clog2(SETTLE_SYMS) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CLK_W-1:0] cnt_clk;
  logic [SAM_W-1:0] cnt_sam;
  logic [SET_W-1:0] settle_cnt;
  logic [LEN_W-1:0] meas_cnt;
  logic [LEN_W-1:0] len_q;
  logic             slip_adv;
  logic             slip_ret;
  logic             start_ok;

  assign sam_clk_ena = (cnt_clk == CLK_W'(CLK_PER_SAM - 1));
  assign sym_clk_ena = sam_clk_ena && (cnt_sam == '0);
  assign start_ok    = (state == IDLE) && meas_start;

  // Free-running sample divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt_clk <= '0;
    else if (sam_clk_ena) cnt_clk <= '0;
    else                  cnt_clk <= cnt_clk + CLK_W'(1);
  end

  // Sample-in-symbol position; a slip shortens or stretches the current symbol by one sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_sam <= '0;
    end else if (sam_clk_ena) begin
      if (slip_adv)                                   cnt_sam <= '0;
      else if (slip_ret)                              cnt_sam <= cnt_sam;
      else if (cnt_sam == SAM_W'(SAM_PER_SYM - 1))    cnt_sam <= '0;
      else                                            cnt_sam <= cnt_sam + SAM_W'(1);
    end
  end

`ifdef RX_TIMING_PHASE_ADJ_EN
  logic pend_adv;
  logic pend_ret;
  logic adv_any;
  logic ret_any;
  logic cancel;

  assign adv_any  = pend_adv | phase_adv;
  assign ret_any  = pend_ret | phase_ret;
  assign cancel   = adv_any & ret_any;
  assign slip_adv = pend_adv & ~cancel & sam_clk_ena & (cnt_sam == SAM_W'(SAM_PER_SYM - 2));
  assign slip_ret = pend_ret & ~cancel & sam_clk_ena & (cnt_sam == SAM_W'(SAM_PER_SYM - 1));

  // Opposing requests annihilate; a repeat request while one is pending is absorbed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_adv  <= 1'b0;
      pend_ret  <= 1'b0;
      phase_ofs <= '0;
    end else begin
      if (cancel) begin
        pend_adv <= 1'b0;
        pend_ret <= 1'b0;
      end else begin
        pend_adv <= adv_any & ~slip_adv;
        pend_ret <= ret_any & ~slip_ret;
      end
      if (slip_adv)
        phase_ofs <= (phase_ofs == OFS_W'(SAM_PER_SYM - 1)) ? '0 : phase_ofs + OFS_W'(1);
      else if (slip_ret)
        phase_ofs <= (phase_ofs == '0) ? OFS_W'(SAM_PER_SYM - 1) : phase_ofs - OFS_W'(1);
    end
  end
`else
  logic unused_phase;

  assign unused_phase = phase_adv ^ phase_ret;
  assign slip_adv     = 1'b0;
  assign slip_ret     = 1'b0;
  assign phase_ofs    = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    meas_busy = 1'b0;
    meas_done = 1'b0;
    case (state)
      IDLE: begin
        if (meas_start) state_nxt = SETTLE;
      end
      SETTLE: begin
        meas_busy = 1'b1;
        if (sym_clk_ena && (settle_cnt == SET_W'(SETTLE_SYMS - 1))) begin
          acc_clear = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        meas_busy = 1'b1;
        acc_en    = 1'b1;
        if (sym_clk_ena && (meas_cnt == len_q - LEN_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        meas_busy = 1'b1;
        meas_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters; a slip during settling restarts the settling count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      meas_cnt   <= '0;
      len_q      <= '0;
    end else if (start_ok) begin
      len_q      <= (meas_len == '0) ? LEN_W'(1) : meas_len;
      settle_cnt <= '0;
      meas_cnt   <= '0;
    end else if (state == SETTLE) begin
      if (slip_adv || slip_ret) settle_cnt <= '0;
      else if (sym_clk_ena)     settle_cnt <= settle_cnt + SET_W'(1);
    end else if ((state == MEASURE) && sym_clk_ena) begin
      meas_cnt <= meas_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_timing_ctrl.sv
// Bench for rx_timing_ctrl: schedule-based reference model checked every cycle, plus literal event timings.
module tb_rx_timing_ctrl;

  localparam int CPS   = 4;
  localparam int SPS   = 4;
  localparam int SET   = 32;
  localparam int LEN_W = 20;
`ifdef RX_TIMING_PHASE_ADJ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             meas_start;
  logic [LEN_W-1:0] meas_len;
  logic             phase_adv;
  logic             phase_ret;
  logic             sam_clk_ena;
  logic             sym_clk_ena;
  logic             acc_clear;
  logic             acc_en;
  logic             meas_busy;
  logic             meas_done;
  logic [1:0]       phase_ofs;

  rx_timing_ctrl #(
    .CLK_PER_SAM(CPS), .SAM_PER_SYM(SPS), .SETTLE_SYMS(SET), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .meas_start(meas_start), .meas_len(meas_len),
    .phase_adv(phase_adv), .phase_ret(phase_ret), .sam_clk_ena(sam_clk_ena),
    .sym_clk_ena(sym_clk_ena), .acc_clear(acc_clear), .acc_en(acc_en),
    .meas_busy(meas_busy), .meas_done(meas_done), .phase_ofs(phase_ofs)
  );

  always #5 clk = ~clk;

  // Reference model: absolute cycle count, sample index and the sample index of the next symbol
  int m_edges, m_samp, m_next, m_ofs, m_mode, m_cnt, m_len;
  bit m_pa, m_pr;
  int n_edges, n_samp, n_next, n_ofs, n_mode, n_cnt, n_len;
  bit n_pa, n_pr;
  bit e_sam, e_sym, e_clr;
  bit adv_any, ret_any;

  always_comb begin
    e_sam   = ((m_edges + 1) % CPS) == 0;
    e_sym   = e_sam && (m_samp == m_next);
    e_clr   = (m_mode == 1) && e_sym && (m_cnt == SET - 1);
    n_edges = m_edges + 1;
    n_samp  = m_samp + (e_sam ? 1 : 0);
    n_next  = m_next;
    n_ofs   = m_ofs;
    n_pa    = m_pa;
    n_pr    = m_pr;
    n_mode  = m_mode;
    n_cnt   = m_cnt;
    n_len   = m_len;
    adv_any = m_pa || phase_adv;
    ret_any = m_pr || phase_ret;
    case (m_mode)
      0: if (meas_start) begin
           n_mode = 1;
           n_cnt  = 0;
           n_len  = (meas_len == '0) ? 1 : int'(meas_len);
         end
      1: if (e_sym) begin
           if (m_cnt + 1 == SET) begin n_mode = 2; n_cnt = 0; end
           else n_cnt = m_cnt + 1;
         end
      2: if (e_sym) begin
           if (m_cnt + 1 == m_len) n_mode = 3;
           else n_cnt = m_cnt + 1;
         end
      default: n_mode = 0;
    endcase
    if (e_sym) n_next = m_samp + SPS;
    if (EN) begin
      if (adv_any && ret_any) begin
        n_pa = 1'b0;
        n_pr = 1'b0;
      end else begin
        n_pa = adv_any;
        n_pr = ret_any;
        if (e_sam && m_pa && (m_samp == n_next - 2)) begin
          n_next = n_next - 1;
          n_ofs  = (m_ofs + 1) % SPS;
          n_pa   = 1'b0;
          if (m_mode == 1) n_cnt = 0;
        end else if (e_sam && m_pr && (m_samp == n_next - 1)) begin
          n_next = n_next + 1;
          n_ofs  = (m_ofs + SPS - 1) % SPS;
          n_pr   = 1'b0;
          if (m_mode == 1) n_cnt = 0;
        end
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges <= 0; m_samp <= 0; m_next <= 0; m_ofs <= 0;
      m_mode <= 0; m_cnt <= 0; m_len <= 0; m_pa <= 1'b0; m_pr <= 1'b0;
    end else begin
      m_edges <= n_edges; m_samp <= n_samp; m_next <= n_next; m_ofs <= n_ofs;
      m_mode <= n_mode; m_cnt <= n_cnt; m_len <= n_len; m_pa <= n_pa; m_pr <= n_pr;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int sym_q[$];
  int first_sam, clr_cyc, done_cyc, done_cnt, acc_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, m_edges + 1, $time);
    end
  endtask

  function automatic int sym_at(input int i);
    if (i < sym_q.size()) return sym_q[i];
    return -1;
  endfunction

  task automatic clear_rec();
    sym_q.delete();
    first_sam = 0; clr_cyc = 0; done_cyc = 0; done_cnt = 0; acc_cnt = 0;
  endtask

  // Per-cycle comparison against the model, plus event recording for the literal checks
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("sam_clk_ena", int'(sam_clk_ena), int'(e_sam));
      chk("sym_clk_ena", int'(sym_clk_ena), int'(e_sym));
      chk("acc_clear",   int'(acc_clear),   int'(e_clr));
      chk("acc_en",      int'(acc_en),      int'(m_mode == 2));
      chk("meas_busy",   int'(meas_busy),   int'(m_mode != 0));
      chk("meas_done",   int'(meas_done),   int'(m_mode == 3));
      chk("phase_ofs",   int'(phase_ofs),   m_ofs);
      if (!reset) begin
        if (sam_clk_ena && first_sam == 0) first_sam = m_edges + 1;
        if (sym_clk_ena) sym_q.push_back(m_edges + 1);
        if (acc_clear) clr_cyc = m_edges + 1;
        if (meas_done) begin done_cyc = m_edges + 1; done_cnt++; end
        if (acc_en && sym_clk_ena) acc_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; meas_start = 1'b0; phase_adv = 1'b0; phase_ret = 1'b0; meas_len = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_rec();
  endtask

  task automatic goto_cycle(input int s);
    while (m_edges + 1 < s) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int len);
    meas_len = LEN_W'(len);
    meas_start = 1'b1;
    @(posedge clk); #1;
    meas_start = 1'b0;
  endtask

  function automatic int outs_word();
    return int'({sam_clk_ena, sym_clk_ena, acc_clear, acc_en, meas_busy, meas_done, phase_ofs});
  endfunction

  initial begin
    reset = 1'b1; meas_start = 1'b0; phase_adv = 1'b0; phase_ret = 1'b0; meas_len = '0;
    clear_rec();
    fork
      compare_loop();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state and free-running strobe cadence
    @(posedge clk); #2;
    chk("reset_outs", outs_word(), 0);
    do_reset();
    goto_cycle(40);
    chk("first_sam", first_sam, 4);
    chk("sym0", sym_at(0), 4);
    chk("sym1", sym_at(1), 20);
    chk("sym2", sym_at(2), 36);

    // Measurement window of 8 symbols; a second start while busy is ignored
    do_reset();
    goto_cycle(30);  pulse_start(8);
    goto_cycle(300); pulse_start(2);
    goto_cycle(700);
    chk("win8_clear_cyc", clr_cyc, 532);
    chk("win8_done_cyc", done_cyc, 661);
    chk("win8_acc_strobes", acc_cnt, 8);
    chk("win8_done_pulses", done_cnt, 1);

    // Advance request (repeated while pending)
    do_reset();
    goto_cycle(10);
    phase_adv = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    phase_adv = 1'b0;
    goto_cycle(60);
    chk("adv_sym1", sym_at(1), EN ? 16 : 20);
    chk("adv_sym2", sym_at(2), EN ? 32 : 36);
    chk("adv_ofs", int'(phase_ofs), EN ? 1 : 0);

    // Retard request
    do_reset();
    goto_cycle(10);
    phase_ret = 1'b1;
    @(posedge clk); #1;
    phase_ret = 1'b0;
    goto_cycle(60);
    chk("ret_sym1", sym_at(1), EN ? 24 : 20);
    chk("ret_sym2", sym_at(2), EN ? 40 : 36);
    chk("ret_ofs", int'(phase_ofs), EN ? 3 : 0);

    // Simultaneous advance and retard cancel
    do_reset();
    goto_cycle(10);
    phase_adv = 1'b1; phase_ret = 1'b1;
    @(posedge clk); #1;
    phase_adv = 1'b0; phase_ret = 1'b0;
    goto_cycle(60);
    chk("both_sym1", sym_at(1), 20);
    chk("both_sym2", sym_at(2), 36);
    chk("both_ofs", int'(phase_ofs), 0);

    // Reset asserted mid-measurement
    do_reset();
    goto_cycle(6); pulse_start(3);
    goto_cycle(540);
    chk("mid_acc_en_pre", int'(acc_en), 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_outs", outs_word(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    goto_cycle(100);
    chk("mid_no_done", done_cnt, 0);

    // Zero length treated as one symbol; start coincident with a strobe; advance during settling
    do_reset();
    goto_cycle(4); pulse_start(0);
    goto_cycle(100);
    phase_adv = 1'b1;
    @(posedge clk); #1;
    phase_adv = 1'b0;
    goto_cycle(700);
    chk("len0_clear_cyc", clr_cyc, EN ? 608 : 516);
    chk("len0_done_cyc", done_cyc, EN ? 625 : 533);
    chk("len0_acc_strobes", acc_cnt, 1);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
